// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit sharing one 32-step shift datapath
// Ports: clk, reset (async, active-high); start/kill request control; funct3 op select;
// a/b source operands; rd_in destination; busy/done status; wb_we/wb_rd/wb_data write port.
module muldiv_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op;
  logic sa, sb;
  logic [31:0] hi, lo, bop;
  logic [5:0] cnt;
  logic accept, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, special;
  logic [31:0] a_mag, b_mag, spec_val, quo, rem, res;
  logic [32:0] mul_sum, rem_sh, diff;
  logic [63:0] prod;
  assign accept = state == IDLE && start && !kill;
  assign a_signed = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign b_signed = funct3 inside {3'b001, 3'b100, 3'b110};
  assign a_neg = a_signed && a[31];
  assign b_neg = b_signed && b[31];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign div_zero = funct3[2] && b == 32'h0;
  assign div_ovf = funct3[2] && !funct3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  assign special = div_zero || div_ovf;
  assign spec_val = div_zero ? (funct3[1] ? a : 32'hFFFF_FFFF) : (funct3[1] ? 32'h0 : 32'h8000_0000);
  // Multiply: hi accumulates the multiplicand while lo shifts the multiplier out and product bits in.
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, bop} : 33'h0);
  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  // The remainder stays below the divisor, so a set bit 32 of the trial difference means negative.
  assign rem_sh = {hi, lo[31]};
  assign diff = rem_sh - {1'b0, bop};
  assign prod = (sa ^ sb) ? -{hi, lo} : {hi, lo};
  assign quo = (sa ^ sb) ? -lo : lo;
  assign rem = sa ? -hi : hi;
  assign res = !op[2] ? (op[1:0] == 2'b00 ? prod[31:0] : prod[63:32]) : (op[1] ? rem : quo);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign wb_we = done && wb_rd != 5'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (special ? DONE : CALC) : IDLE;
      CALC: state_n = kill ? IDLE : (cnt == 6'd31 ? FIX : CALC);
      FIX:  state_n = kill ? IDLE : DONE;
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op <= 3'h0;
      sa <= 1'b0;
      sb <= 1'b0;
      hi <= 32'h0;
      lo <= 32'h0;
      bop <= 32'h0;
      cnt <= 6'h0;
      wb_rd <= 5'h0;
      wb_data <= 32'h0;
    end else if (accept) begin
      op <= funct3;
      sa <= a_neg;
      sb <= b_neg;
      hi <= 32'h0;
      lo <= funct3[2] ? a_mag : b_mag;
      bop <= funct3[2] ? b_mag : a_mag;
      cnt <= 6'h0;
      wb_rd <= rd_in;
      if (special) wb_data <= spec_val;
    end else if (state == CALC) begin
      cnt <= cnt + 6'd1;
      hi <= op[2] ? (diff[32] ? rem_sh[31:0] : diff[31:0]) : mul_sum[32:1];
      lo <= op[2] ? {lo[30:0], !diff[32]} : {mul_sum[0], lo[31:1]};
    end else if (state == FIX && !kill) wb_data <= res;
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed self-checking bench for muldiv_iter
module tb_muldiv_iter;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, kill = 1'b0;
  logic [2:0] funct3 = 3'h0;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic [4:0] rd_in = 5'h0;
  logic busy, done, wb_we;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  muldiv_iter dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .a(a), .b(b), .rd_in(rd_in), .busy(busy), .done(done),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat, input bit inject);
    int lat = 0;
    funct3 = f;
    a = x;
    b = y;
    rd_in = rd;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    while (!done && lat < 40) begin
      if (inject && lat == 10) begin
        start = 1'b1;
        funct3 = 3'b011;
        a = 32'h1234_5678;
        b = 32'h9abc_def0;
        rd_in = 5'd9;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, wb_data, exp);
    check({tag, " we"}, 32'(wb_we), 32'(rd != 5'd0));
    check({tag, " rd"}, 32'(wb_rd), 32'(rd));
    tick();
    check({tag, " done end"}, 32'(done), 32'd0);
    check({tag, " busy end"}, 32'(busy), 32'd0);
    check({tag, " data held"}, wb_data, exp);
  endtask
  initial begin
    bit seen;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset we", 32'(wb_we), 32'd0);
    check("reset rd", 32'(wb_rd), 32'd0);
    check("reset data", wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 33, 1'b0);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu rd0", 3'b101, 32'd100, 32'd7, 5'd0, 32'd14, 33, 1'b0);
    run_op("remu rd5", 3'b111, 32'd100, 32'd7, 5'd5, 32'd2, 33, 1'b0);
    run_op("div by0", 3'b100, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("remu by0", 3'b111, 32'd5, 32'd0, 5'd12, 32'd5, 0, 1'b0);
    run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0, 1'b0);
    run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 0, 1'b0);
    run_op("busy start", 3'b101, 32'd100, 32'd7, 5'd10, 32'd14, 33, 1'b1);
    funct3 = 3'b000;
    a = 32'd3;
    b = 32'd5;
    rd_in = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill busy", 32'(busy), 32'd0);
    check("kill done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("kill no done", 32'(seen), 32'd0);
    check("kill data", wb_data, 32'd14);
    start = 1'b1;
    kill = 1'b1;
    tick();
    start = 1'b0;
    kill = 1'b0;
    check("start+kill busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("start+kill idle", 32'(seen), 32'd0);
    funct3 = 3'b101;
    a = 32'd50;
    b = 32'd3;
    rd_in = 5'd17;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset done", 32'(done), 32'd0);
    check("mid reset we", 32'(wb_we), 32'd0);
    check("mid reset rd", 32'(wb_rd), 32'd0);
    check("mid reset data", wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("post reset idle", 32'(seen), 32'd0);
    run_op("divu after reset", 3'b101, 32'd9, 32'd3, 5'd1, 32'd3, 33, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative RV32M multiply/divide unit for the base CPU. It consumes the two source operands read from the register file and returns a result with a destination index and write strobe that drive the register file write port (`we`/`rd`/`wd`). A shift-add multiplier and a restoring divider share one 32-iteration datapath. The pipeline stalls on `busy`.

## Interface

Parameters: none. The datapath is fixed at XLEN = 32.

Ports:
- `clk`  in  1  System clock. All state changes on the rising edge.
- `reset`  in  1  Asynchronous, active-high. Forces IDLE and clears all registers.
- `start`  in  1  Request strobe. Accepted only in IDLE.
- `kill`  in  1  Abort. Discards any operation in progress.
- `funct3`  in  3  Operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  32  rs1 operand (`rd1` of the register file).
- `b`  in  32  rs2 operand (`rd2` of the register file).
- `rd_in`  in  5  Destination register index.
- `busy`  out  1  High in every state except IDLE.
- `done`  out  1  One-cycle completion pulse.
- `wb_we`  out  1  Equals `done && (wb_rd != 0)`.
- `wb_rd`  out  5  Latched destination index.
- `wb_data`  out  32  Result. Held until the next accepted start.

## Operation

- States: IDLE, CALC, FIX, DONE.
- **IDLE, accept condition:** `start && !kill`.
  - Latch `funct3`, `rd_in`, operand signs and operand magnitudes; clear the 6-bit iteration counter.
  - Signedness: MULH and DIV/REM treat both operands as signed. MULHSU treats `a` as signed and `b` as unsigned. MUL, MULHU, DIVU and REMU treat both as unsigned.
  - Next state is CALC, unless a special case applies (next state DONE directly).
- **Special cases** (signed and unsigned division forms only):
  - Divide by zero (`b == 0`): quotient = 0xFFFFFFFF, remainder = `a`.
  - Signed overflow (DIV/REM with `a` = 0x80000000 and `b` = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- **CALC:** one iteration per cycle, 32 iterations (counter 0..31); after the 32nd iteration, next state is FIX.
  - Multiply: 64-bit accumulator. If multiplier bit i is set, add the multiplicand shifted by i. Equivalent shift-right-accumulate forms are allowed.
  - Divide: restoring algorithm. Shift the remainder left with the next dividend bit, trial-subtract the divisor, set the quotient bit when the result is non-negative.
- **FIX:** apply signs, register the result, next state DONE.
  - Product: negate the 64-bit product when the operand signs differ (signed interpretations only).
  - MUL returns bits [31:0]. MULH, MULHSU and MULHU return bits [63:32].
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- **DONE:** `done` = 1. Next state is IDLE. A `start` in this cycle is ignored.
- **`kill`:** in CALC, FIX or DONE, next state is IDLE. No `done` pulse follows, except that `done` is already high during a DONE cycle. `wb_data` keeps its old value. When `start` and `kill` are both high in IDLE, `kill` wins and the request is not accepted.
- **`start` while busy:** ignored; there is no queuing.
- **Reset values:** state IDLE, `busy` 0, `done` 0, `wb_we` 0, `wb_rd` 0, `wb_data` 0, counter 0.

## Timing

- Edge E0 is the accepting edge.
- Normal path: CALC iterations occur on E1..E32, FIX on E33. `done`/`wb_we` are high from E33 to E34. The result is therefore written into the register file at E34, 34 cycles after acceptance. `busy` is high from E0 to E34.
- Special-case path: DONE is entered at E0. `done` is high from E0 to E1, giving one-cycle latency.
- `wb_data` and `wb_rd` are stable throughout the `done` cycle and afterwards.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. After reset deasserts, the unit is IDLE and no `done` pulse is produced.

## Test plan

- **Multiply, low/high words:**
  - MUL with `a` = 7, `b` = 0xFFFFFFFD → `wb_data` 0xFFFFFFEB. `done` high exactly 34 cycles after acceptance; `busy` high for 34 cycles.
  - MULH with 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU with `a` = 0xFFFFFFFF, `b` = 0xFFFFFFFF → 0xFFFFFFFF.
- **Division and remainder:**
  - DIV with -7 / 2 → 0xFFFFFFFD.
  - REM with -7 % 2 → 0xFFFFFFFF.
  - DIVU with 100 / 7 → 14.
  - REMU with 100 % 7 → 2.
- **Special cases:** each must complete with `done` one cycle after acceptance.
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- **Write-back gating:**
  - `rd_in` = 0 → `done` pulses and `wb_we` stays 0.
  - `rd_in` = 5 → `wb_we` = 1 and `wb_rd` = 5 in the `done` cycle.
- **Ignored start and kill:**
  - `start` pulsed with new operands at cycle 10 of a busy operation → ignored; the original result is returned.
  - `kill` at cycle 10 → `busy` 0 after the next edge, no `done`, `wb_data` unchanged.
  - `start` and `kill` high together in IDLE → not accepted.
- **Reset:**
  - Assert `reset` mid-CALC, between clock edges → all outputs go to 0 immediately.
  - After release, a fresh DIVU 9/3 → 3 with normal latency.
